vram_ctrl: RTL and testbench
============================

# vram_ctrl

Access controller for the 1 kB single-port video RAM. It shares one RAM port among three requesters: video fetch, CPU, and an internal block-operation engine that runs screen clear and one-row scroll-up. It sits between the CPU bus decode, the video timing/fetch logic and the video RAM. It replaces ad-hoc address muxing with a fixed-priority, stall-based arbiter.

## Interface
Parameters:
- `ROW_BYTES`, 32: bytes per text row (scroll distance).
- `MEM_BYTES`, 1024: RAM size; address width is 10.

Ports:
- `clk` in 1: 16 MHz system clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `vid_req` in 1: video fetch slot this cycle; never asserted two cycles in a row.
- `vid_addr` in 10: video fetch address.
- `cpu_sel` in 1: CPU access decoded to video RAM.
- `cpu_we` in 1: CPU write.
- `cpu_addr` in 10: CPU address.
- `cpu_din` in 8: CPU write data.
- `cpu_rdy` out 1: registered; low stalls the CPU.
- `cmd_we` in 1: start a block operation.
- `cmd` in 2: 01 clear, 10 scroll up; 00 and 11 are no-ops.
- `fill` in 8: fill byte, sampled at `cmd_we`.
- `busy` out 1: block operation in progress.
- `ram_addr` out 10: RAM address.
- `ram_we` out 1: RAM write strobe.
- `ram_din` out 8: RAM write data.
- `ram_dout` in 8: RAM read data, valid 1 cycle after the read address.

## Operation
- Priority per cycle, highest first:
  - video;
  - replayed CPU access;
  - live CPU access;
  - engine.
- `ram_addr`, `ram_we` and `ram_din` are combinational from the winning requester. With no grant: `ram_we`=0, `ram_addr`=0, `ram_din`=0.
- Video grant drives `vid_addr` with `ram_we`=0.
- CPU collision: when `cpu_sel` and `vid_req` are both high, capture addr/we/din. Next cycle, `cpu_rdy`=0 and the captured access is replayed, which is guaranteed because video cannot repeat. `cpu_rdy` returns to 1 the following cycle.
- CPU read data is on `ram_dout` the cycle after the grant (live or replay).
- Engine FSM states: IDLE, CLR, SCR_RD, SCR_WR, SCR_FILL. It advances only on a cycle it is granted.
  - IDLE + `cmd_we`, cmd=01 → CLR, with cnt=0 and fill latched.
  - IDLE + `cmd_we`, cmd=10 → SCR_RD, with cnt=0.
  - CLR: write `fill` at cnt; cnt++. After cnt=1023 → IDLE.
  - SCR_RD: read cnt+32 → SCR_WR. The cycle after the read grant, `ram_dout` is captured into a hold register unconditionally, even if that cycle is stolen.
  - SCR_WR: write hold data at cnt; cnt++. Then go to SCR_RD, or to SCR_FILL after cnt=991.
  - SCR_FILL: write `fill` at cnt (992..1023). After 1023 → IDLE.
- `busy` is high in every non-IDLE state.
- `cmd_we` while busy is ignored. No queueing.
- cnt is 10 bits and never wraps mid-operation; the terminal compare is exact.
- The CPU may access RAM during an engine operation. CPU writes to a not-yet-processed area may be overwritten; this is documented behaviour.

## Timing
- Reset values: `cpu_rdy`=1, `busy`=0, FSM=IDLE, cnt=0, hold=0, no pending replay. RAM outputs are idle (we=0).
- Reset mid-operation aborts immediately. The RAM is left partially processed.
- `busy` rises the cycle after `cmd_we`. `busy` falls the cycle after the last engine write.
- Uncontended clear: 1024 cycles. Uncontended scroll: 992×2 + 32 = 2016 cycles.
- The stall is exactly 1 cycle per collision. Without a collision the CPU never stalls.
- A `vid_req` in the same cycle as an engine read-capture does not corrupt the hold data.

## Structure
- Shared package `vram_pkg`:
  - `ROW_BYTES`, `MEM_BYTES`;
  - cmd encodings (`CMD_NOP`, `CMD_CLR`, `CMD_SCROLL`);
  - engine state enum.
- Natural sub-module: `vram_blkop`, which holds the engine FSM, counter, hold and fill registers. It presents request/addr/we/data and takes a grant from the arbiter. The arbiter and CPU replay logic stay in `vram_ctrl`.

## Test plan
- CPU write 0x41 to 0x005 with no `vid_req` → `ram_we`=1 at 0x005 the same cycle; `cpu_rdy` stays 1.
- CPU read 0x010 colliding with `vid_req` at 0x020:
  - ram_addr=0x020, then 0x010 next cycle;
  - `cpu_rdy`=0 for exactly 1 cycle;
  - data is on `ram_dout` the cycle after the replay.
- Clear with fill=0x20 and no traffic → `busy` high for 1024 cycles; all 1024 locations read back 0x20.
- Scroll with RAM preloaded (mem[i] = i[7:0]) and fill=0x20:
  - mem[0..991] = old mem[32..1023];
  - mem[992..1023] = 0x20;
  - `busy` lasts 2016 cycles.
- Scroll with `vid_req` every 3rd cycle plus random CPU reads → same final RAM contents as the previous case; video is never delayed.
- `reset_n` low at cnt=500 of a clear → `busy`=0 immediately; a new `cmd_we` after reset starts a new operation from cnt=0.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared constants, command encodings and engine states for vram_ctrl
package vram_pkg;
  localparam int ROW_BYTES = 32;
  localparam int MEM_BYTES = 1024;
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_CLR = 2'b01;
  localparam logic [1:0] CMD_SCROLL = 2'b10;
  typedef enum logic [2:0] {ST_IDLE, ST_CLR, ST_SCR_RD, ST_SCR_WR, ST_SCR_FILL} eng_state_e;
endpackage

// File: rtl/vram_blkop.sv
// vram_blkop: block-operation engine (screen clear and one-row scroll-up) requesting the shared RAM port
module vram_blkop
  import vram_pkg::*;
#(
  parameter int ROW_BYTES = vram_pkg::ROW_BYTES,
  parameter int MEM_BYTES = vram_pkg::MEM_BYTES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_we,
  input  logic [1:0] cmd,
  input  logic [7:0] fill,
  input  logic       gnt,
  input  logic [7:0] ram_dout,
  output logic       req,
  output logic [9:0] addr,
  output logic       we,
  output logic [7:0] wdata,
  output logic       busy
);
  localparam logic [9:0] LAST = 10'(MEM_BYTES - 1);
  localparam logic [9:0] LAST_MOVE = 10'(MEM_BYTES - ROW_BYTES - 1);
  localparam logic [9:0] ROW = 10'(ROW_BYTES);
  eng_state_e state_q;
  logic [9:0] cnt_q;
  logic [7:0] hold_q;
  logic [7:0] fill_q;
  logic       rd_q;
  assign busy = state_q != ST_IDLE;
  assign req = busy;
  assign we = state_q inside {ST_CLR, ST_SCR_WR, ST_SCR_FILL};
  assign addr = state_q == ST_SCR_RD ? cnt_q + ROW : cnt_q;
  // the write right after a granted read takes ram_dout directly, since hold_q only updates at that edge
  assign wdata = state_q != ST_SCR_WR ? fill_q : rd_q ? ram_dout : hold_q;
  // engine FSM: advances only on granted cycles; read data is captured the cycle after a read grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      hold_q <= '0;
      fill_q <= '0;
      rd_q <= 1'b0;
    end else begin
      rd_q <= gnt && state_q == ST_SCR_RD;
      if (rd_q) hold_q <= ram_dout;
      case (state_q)
        ST_IDLE: if (cmd_we && (cmd == CMD_CLR || cmd == CMD_SCROLL)) begin
          state_q <= cmd == CMD_CLR ? ST_CLR : ST_SCR_RD;
          cnt_q <= '0;
          fill_q <= fill;
        end
        ST_SCR_RD: if (gnt) state_q <= ST_SCR_WR;
        ST_SCR_WR: if (gnt) begin
          cnt_q <= cnt_q + 10'd1;
          state_q <= cnt_q == LAST_MOVE ? ST_SCR_FILL : ST_SCR_RD;
        end
        ST_CLR, ST_SCR_FILL: if (gnt) begin
          cnt_q <= cnt_q + 10'd1;
          if (cnt_q == LAST) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/vram_ctrl.sv
// vram_ctrl: fixed-priority, stall-based arbiter sharing the video RAM port among video, CPU and block engine
module vram_ctrl
  import vram_pkg::*;
#(
  parameter int ROW_BYTES = vram_pkg::ROW_BYTES,
  parameter int MEM_BYTES = vram_pkg::MEM_BYTES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vid_req,
  input  logic [9:0] vid_addr,
  input  logic       cpu_sel,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic       cpu_rdy,
  input  logic       cmd_we,
  input  logic [1:0] cmd,
  input  logic [7:0] fill,
  output logic       busy,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);
  logic       rp_q;
  logic       rp_we_q;
  logic [9:0] rp_addr_q;
  logic [7:0] rp_din_q;
  logic       coll;
  logic       live_g;
  logic       eng_req;
  logic       eng_gnt;
  logic       eng_we;
  logic [9:0] eng_addr;
  logic [7:0] eng_din;
  assign coll = cpu_sel && vid_req && !rp_q;
  assign live_g = cpu_sel && !vid_req && !rp_q;
  assign eng_gnt = eng_req && !vid_req && !rp_q && !cpu_sel;
  assign cpu_rdy = !rp_q;
  vram_blkop #(.ROW_BYTES(ROW_BYTES), .MEM_BYTES(MEM_BYTES)) u_blkop (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_we(cmd_we),
    .cmd(cmd),
    .fill(fill),
    .gnt(eng_gnt),
    .ram_dout(ram_dout),
    .req(eng_req),
    .addr(eng_addr),
    .we(eng_we),
    .wdata(eng_din),
    .busy(busy)
  );
  // port mux, highest priority first: video, replayed CPU, live CPU, engine
  always_comb begin
    ram_addr = vid_req ? vid_addr : rp_q ? rp_addr_q : live_g ? cpu_addr : eng_gnt ? eng_addr : '0;
    ram_we = !vid_req && (rp_q ? rp_we_q : live_g ? cpu_we : eng_gnt && eng_we);
    ram_din = vid_req ? '0 : rp_q ? rp_din_q : live_g ? cpu_din : eng_gnt ? eng_din : '0;
  end
  // a CPU access that loses to video is captured and replayed next cycle while cpu_rdy is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rp_q <= 1'b0;
      rp_we_q <= 1'b0;
      rp_addr_q <= '0;
      rp_din_q <= '0;
    end else begin
      rp_q <= coll;
      if (coll) begin
        rp_we_q <= cpu_we;
        rp_addr_q <= cpu_addr;
        rp_din_q <= cpu_din;
      end
    end
  end
endmodule

// File: tb/tb_vram_ctrl.sv
// tb_vram_ctrl: directed and randomized checks of vram_ctrl against a behavioural RAM and reference image
module tb_vram_ctrl;
  import vram_pkg::*;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vid_req = 1'b0;
  logic [9:0] vid_addr = '0;
  logic       cpu_sel = 1'b0;
  logic       cpu_we = 1'b0;
  logic [9:0] cpu_addr = '0;
  logic [7:0] cpu_din = '0;
  logic       cmd_we = 1'b0;
  logic [1:0] cmd = '0;
  logic [7:0] fill = '0;
  logic       cpu_rdy;
  logic       busy;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [7:0] mem [1024];
  logic [7:0] ref_m [1024];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vram_ctrl #(.ROW_BYTES(32), .MEM_BYTES(1024)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vid_req(vid_req),
    .vid_addr(vid_addr),
    .cpu_sel(cpu_sel),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din(cpu_din),
    .cpu_rdy(cpu_rdy),
    .cmd_we(cmd_we),
    .cmd(cmd),
    .fill(fill),
    .busy(busy),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // behavioural single-port RAM: read data one cycle after the address
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mem_diff();
    int d = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_m[i]) d++;
    return d;
  endfunction

  task automatic preload();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      cpu_sel = 1'b1;
      cpu_we = 1'b1;
      cpu_addr = 10'(i);
      cpu_din = 8'(i);
    end
    @(negedge clk);
    cpu_sel = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic start_cmd(input logic [1:0] c, input logic [7:0] f);
    @(negedge clk);
    cmd_we = 1'b1;
    cmd = c;
    fill = f;
    @(negedge clk);
    cmd_we = 1'b0;
    fill = 8'h77;
  endtask

  task automatic run(input bit poke, output int cyc);
    cyc = 0;
    while (busy && cyc < 5000) begin
      cmd_we = poke && cyc == 10;
      cmd = CMD_SCROLL;
      cyc++;
      @(negedge clk);
    end
    cmd_we = 1'b0;
  endtask

  initial begin
    int cyc;
    bit pend;
    bit coll_prev;
    logic [7:0] pend_val;
    repeat (2) @(negedge clk);
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    reset_n = 1'b1;

    @(negedge clk);
    cpu_sel = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 10'h005;
    cpu_din = 8'h41;
    #1;
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 10'h005);
    chk("wr_din", ram_din, 8'h41);
    @(negedge clk);
    chk("wr_rdy", cpu_rdy, 1);
    chk("wr_mem", mem[5], 8'h41);
    cpu_addr = 10'h010;
    cpu_din = 8'h5A;
    @(negedge clk);
    cpu_we = 1'b0;
    vid_req = 1'b1;
    vid_addr = 10'h020;
    #1;
    chk("col_vaddr", ram_addr, 10'h020);
    chk("col_vwe", ram_we, 0);
    chk("col_rdy0", cpu_rdy, 1);
    @(negedge clk);
    vid_req = 1'b0;
    #1;
    chk("col_rdy1", cpu_rdy, 0);
    chk("col_raddr", ram_addr, 10'h010);
    chk("col_rwe", ram_we, 0);
    @(negedge clk);
    chk("col_rdy2", cpu_rdy, 1);
    chk("col_data", ram_dout, 8'h5A);
    cpu_sel = 1'b0;

    @(negedge clk);
    cmd_we = 1'b1;
    cmd = CMD_CLR;
    fill = 8'h20;
    #1;
    chk("clr_busy_pre", busy, 0);
    @(negedge clk);
    cmd_we = 1'b0;
    fill = 8'h77;
    chk("clr_busy_rise", busy, 1);
    run(1, cyc);
    chk("clr_cycles", cyc, 1024);
    for (int i = 0; i < 1024; i++) ref_m[i] = 8'h20;
    chk("clr_mem", mem_diff(), 0);

    preload();
    for (int i = 0; i < 1024; i++) ref_m[i] = i < 992 ? 8'(i + 32) : 8'h20;
    start_cmd(CMD_SCROLL, 8'h20);
    chk("scr_busy_rise", busy, 1);
    run(0, cyc);
    chk("scr_cycles", cyc, 2016);
    chk("scr_mem", mem_diff(), 0);

    preload();
    start_cmd(CMD_SCROLL, 8'h20);
    cyc = 0;
    pend = 1'b0;
    coll_prev = 1'b0;
    pend_val = '0;
    while (busy && cyc < 8000) begin
      if (pend) chk("trf_rdata", ram_dout, pend_val);
      chk("trf_rdy", cpu_rdy, !coll_prev);
      vid_req = cyc % 3 == 0;
      vid_addr = 10'($urandom);
      if (cpu_rdy) begin
        cpu_sel = $urandom_range(0, 2) == 0;
        cpu_we = 1'b0;
        cpu_addr = 10'($urandom);
      end
      #1;
      if (vid_req) begin
        chk("trf_vaddr", ram_addr, vid_addr);
        chk("trf_vwe", ram_we, 0);
      end
      pend = cpu_sel && !vid_req;
      if (pend) begin
        chk("trf_caddr", ram_addr, cpu_addr);
        pend_val = mem[cpu_addr];
      end
      coll_prev = cpu_sel && vid_req && cpu_rdy;
      cyc++;
      @(negedge clk);
    end
    vid_req = 1'b0;
    cpu_sel = 1'b0;
    chk("trf_done", busy, 0);
    chk("trf_mem", mem_diff(), 0);

    start_cmd(CMD_CLR, 8'h55);
    repeat (500) @(negedge clk);
    #1;
    chk("abort_cnt", ram_addr, 500);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_we", ram_we, 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_m499", mem[499], 8'h55);
    chk("abort_m500", mem[500], 8'h14);
    start_cmd(CMD_CLR, 8'h66);
    #1;
    chk("restart_busy", busy, 1);
    chk("restart_addr", ram_addr, 0);
    chk("restart_din", ram_din, 8'h66);
    chk("restart_we", ram_we, 1);
    run(0, cyc);
    chk("restart_cycles", cyc, 1024);
    for (int i = 0; i < 1024; i++) ref_m[i] = 8'h66;
    chk("restart_mem", mem_diff(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
